// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch resolution unit.
//   bru_state_e : resolution FSM states (RUN, FLUSH)
//   bru_entry_t : one in-flight prediction {pc, taken, target}
//   INSTR_BYTES : fall-through distance used for not-taken redirects
// Address fields are sized to ADDR_MAX_BITS so one struct serves every
// ADDRESS_BITS instantiation; narrower addresses are zero-extended and the
// constant upper bits disappear in synthesis.
package bpu_pkg;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam int unsigned ADDR_MAX_BITS = 64;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic [ADDR_MAX_BITS-1:0] pc;
    logic                     taken;
    logic [ADDR_MAX_BITS-1:0] target;
  } bru_entry_t;

  // Address of the instruction following a branch at 'pc'.
  function automatic logic [ADDR_MAX_BITS-1:0] fallthrough_pc(
    input logic [ADDR_MAX_BITS-1:0] pc
  );
    return pc + ADDR_MAX_BITS'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order FIFO holding in-flight branch predictions.
//   clk, rst        : clock, asynchronous active-high reset
//   i_push/i_push_data : enqueue one entry (ignored when full or clearing)
//   i_pop           : dequeue the head entry (ignored when empty or clearing)
//   i_clear         : drop every entry; dominates push and pop
//   o_head          : oldest entry (valid while !o_empty)
//   o_full/o_empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module bru_pred_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: queues predictions from the branch predictor,
// compares the oldest one against the execute-stage outcome, trains the
// predictor on every resolution and flushes/redirects fetch on mispredict.
//   clk, reset                         : clock, asynchronous active-high reset
//   pred_valid/pc/taken/target, pred_ready : prediction push interface
//   res_valid/taken/target, res_ready  : resolution (pop) interface
//   update_valid, update_pc, actual_pred : predictor training strobe
//   flush, redirect_pc                 : one-cycle flush pulse + restart PC
//   mispredict_count                   : saturating mispredict counter
module branch_resolution_unit
  import bpu_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 32,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pred_valid,
  input  logic [ADDRESS_BITS-1:0] pred_pc,
  input  logic                    pred_taken,
  input  logic [ADDRESS_BITS-1:0] pred_target,
  output logic                    pred_ready,
  input  logic                    res_valid,
  input  logic                    res_taken,
  input  logic [ADDRESS_BITS-1:0] res_target,
  output logic                    res_ready,
  output logic                    update_valid,
  output logic [ADDRESS_BITS-1:0] update_pc,
  output logic                    actual_pred,
  output logic                    flush,
  output logic [ADDRESS_BITS-1:0] redirect_pc,
  output logic [15:0]             mispredict_count
);

  bru_state_e              r_state;
  logic                    r_update_valid;
  logic [ADDRESS_BITS-1:0] r_update_pc;
  logic                    r_actual_pred;
  logic                    r_flush;
  logic [ADDRESS_BITS-1:0] r_redirect_pc;
  logic [15:0]             r_mispredict_count;

  bru_entry_t              w_push_entry;
  bru_entry_t              w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_target_miss;
  logic                    w_mispredict;
  logic [ADDRESS_BITS-1:0] w_head_pc;
  logic [ADDRESS_BITS-1:0] w_fallthrough;
  logic [ADDRESS_BITS-1:0] w_redirect;

  // Handshakes: nothing is accepted or resolved during the flush cycle.
  assign pred_ready = (r_state == RUN) && !w_full;
  assign res_ready  = (r_state == RUN) && !w_empty;
  assign w_push     = pred_valid && pred_ready;
  assign w_pop      = res_valid && res_ready;

  always_comb begin
    w_push_entry        = '0;
    w_push_entry.pc     = ADDR_MAX_BITS'(pred_pc);
    w_push_entry.taken  = pred_taken;
    w_push_entry.target = ADDR_MAX_BITS'(pred_target);
  end

  // A push coinciding with a mispredicting pop is discarded by the clear.
  bru_pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(bru_entry_t))
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_clear     (w_mispredict),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Target only matters when the branch was actually taken.
  assign w_target_miss = (w_head.target != ADDR_MAX_BITS'(res_target));
  assign w_mispredict  = w_pop &&
                         ((w_head.taken != res_taken) || (res_taken && w_target_miss));

  assign w_head_pc     = ADDRESS_BITS'(w_head.pc);
  assign w_fallthrough = ADDRESS_BITS'(fallthrough_pc(w_head.pc));
  assign w_redirect    = res_taken ? res_target : w_fallthrough;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= RUN;
      r_update_valid <= 1'b0;
      r_update_pc    <= '0;
      r_actual_pred  <= 1'b0;
      r_flush        <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_update_valid <= w_pop;
      r_flush        <= w_mispredict;
      if (w_pop) begin
        r_update_pc   <= w_head_pc;
        r_actual_pred <= res_taken;
      end
      if (w_mispredict) begin
        r_redirect_pc <= w_redirect;
      end
      case (r_state)
        RUN:     if (w_mispredict) r_state <= FLUSH;
        FLUSH:   r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mispredict_count <= '0;
    end else if (w_mispredict && (r_mispredict_count != '1)) begin
      r_mispredict_count <= r_mispredict_count + 16'd1;
    end
  end

  assign update_valid     = r_update_valid;
  assign update_pc        = r_update_pc;
  assign actual_pred      = r_actual_pred;
  assign flush            = r_flush;
  assign redirect_pc      = r_redirect_pc;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolution_unit.sv
module tb_branch_resolution_unit;

  localparam int AB = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pred_valid;
  logic [AB-1:0] pred_pc;
  logic          pred_taken;
  logic [AB-1:0] pred_target;
  logic          pred_ready;
  logic          res_valid;
  logic          res_taken;
  logic [AB-1:0] res_target;
  logic          res_ready;
  logic          update_valid;
  logic [AB-1:0] update_pc;
  logic          actual_pred;
  logic          flush;
  logic [AB-1:0] redirect_pc;
  logic [15:0]   mispredict_count;

  branch_resolution_unit #(
    .ADDRESS_BITS (AB),
    .DEPTH        (D)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .pred_ready       (pred_ready),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .res_ready        (res_ready),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .actual_pred      (actual_pred),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Reference model: a queue of outstanding predictions plus expected outputs.
  typedef struct {
    logic [AB-1:0] pc;
    logic          taken;
    logic [AB-1:0] tgt;
  } ent_t;

  ent_t          q[$];
  logic          m_flush_cyc;
  logic          m_uv;
  logic          m_flush;
  logic          m_ap;
  logic [AB-1:0] m_upc;
  logic [AB-1:0] m_redir;
  int unsigned   m_cnt;

  logic          r_pv, r_pt, r_rv, r_rt;
  logic [AB-1:0] r_ppc, r_ptg, r_rtg;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s %s observed=%0h expected=%0h", phase, name, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush_cyc = 1'b0;
    m_uv        = 1'b0;
    m_flush     = 1'b0;
    m_ap        = 1'b0;
    m_upc       = '0;
    m_redir     = '0;
    m_cnt       = 0;
  endtask

  task automatic check_all();
    chk("pred_ready",   pred_ready,       (!m_flush_cyc && q.size() < D));
    chk("res_ready",    res_ready,        (!m_flush_cyc && q.size() > 0));
    chk("update_valid", update_valid,     m_uv);
    chk("update_pc",    update_pc,        m_upc);
    chk("actual_pred",  actual_pred,      m_ap);
    chk("flush",        flush,            m_flush);
    chk("redirect_pc",  redirect_pc,      m_redir);
    chk("count",        mispredict_count, m_cnt);
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input logic pv, input logic [AB-1:0] ppc, input logic pt,
                      input logic [AB-1:0] ptg, input logic rv, input logic rt,
                      input logic [AB-1:0] rtg);
    logic can_push, can_pop, mis;
    ent_t h;
    check_all();
    pred_valid  = pv;
    pred_pc     = ppc;
    pred_taken  = pt;
    pred_target = ptg;
    res_valid   = rv;
    res_taken   = rt;
    res_target  = rtg;
    can_push = pv && !m_flush_cyc && (q.size() < D);
    can_pop  = rv && !m_flush_cyc && (q.size() > 0);
    mis      = 1'b0;
    m_uv     = can_pop;
    m_flush  = 1'b0;
    if (can_pop) begin
      h     = q[0];
      mis   = (h.taken != rt) || (rt && (h.tgt != rtg));
      m_upc = h.pc;
      m_ap  = rt;
      if (mis) begin
        m_flush = 1'b1;
        m_redir = rt ? rtg : h.pc + 32'd4;
        if (m_cnt < 32'hFFFF) m_cnt++;
        q.delete();
        can_push = 1'b0;
      end else begin
        void'(q.pop_front());
      end
    end
    if (can_push) q.push_back('{pc: ppc, taken: pt, tgt: ptg});
    m_flush_cyc = mis;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic push(input logic [AB-1:0] ppc, input logic pt, input logic [AB-1:0] ptg);
    step(1'b1, ppc, pt, ptg, 1'b0, 1'b0, '0);
  endtask

  // Optional push while resolving the model's head with its own prediction.
  task automatic step_good(input logic pv, input logic [AB-1:0] ppc, input logic pt,
                           input logic [AB-1:0] ptg);
    if (q.size() > 0) step(pv, ppc, pt, ptg, 1'b1, q[0].taken, q[0].tgt);
    else              step(pv, ppc, pt, ptg, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset       = 1'b1;
    pred_valid  = 1'b0;
    pred_pc     = '0;
    pred_taken  = 1'b0;
    pred_target = '0;
    res_valid   = 1'b0;
    res_taken   = 1'b0;
    res_target  = '0;
    model_reset();
    @(negedge clk);
    phase = "reset";
    check_all();
    reset = 1'b0;

    phase = "correct";
    push(32'h10, 1'b1, 32'h30);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h30);
    idle();

    phase = "mis_taken";
    push(32'h20, 1'b0, 32'h0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h80);
    idle();
    idle();

    phase = "mis_nottaken";
    push(32'h3C, 1'b1, 32'h100);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h0);
    idle();
    idle();

    phase = "pc_wrap";
    push(32'hFFFF_FFFC, 1'b1, 32'h200);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h0);
    idle();

    phase = "target_only";
    push(32'h44, 1'b1, 32'h300);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h304);
    idle();
    push(32'h48, 1'b0, 32'h999);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h123);
    idle();

    phase = "full";
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 4), i[0], 32'h2000 + 32'(i * 8));
    step_good(1'b1, 32'h5000, 1'b1, 32'h5100);
    step(1'b1, 32'h5004, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    phase = "laps";
    for (int i = 0; i < 16; i++) step_good(1'b1, 32'h6000 + 32'(i * 4), i[1], 32'h7000 + 32'(i * 16));
    while (q.size() > 0) step_good(1'b0, '0, 1'b0, '0);
    idle();

    phase = "mis_with_push";
    for (int i = 0; i < 3; i++) push(32'h8000 + 32'(i * 4), 1'b1, 32'h9000);
    step(1'b1, 32'h8100, 1'b1, 32'h9100, 1'b1, 1'b0, 32'h0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h9000);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h9000);
    idle();

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      r_pv  = ($urandom_range(0, 3) != 0);
      r_ppc = 32'($urandom) & 32'hFFFF_FFFC;
      r_pt  = 1'($urandom_range(0, 1));
      r_ptg = 32'($urandom_range(1, 4)) << 8;
      r_rv  = ($urandom_range(0, 2) != 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        r_rt  = q[0].taken;
        r_rtg = q[0].tgt;
      end else begin
        r_rt  = 1'($urandom_range(0, 1));
        r_rtg = 32'($urandom_range(1, 4)) << 8;
      end
      step(r_pv, r_ppc, r_pt, r_ptg, r_rv, r_rt, r_rtg);
    end
    while (q.size() > 0 || m_flush_cyc) step_good(1'b0, '0, 1'b0, '0);
    idle();

    phase = "saturate";
    force dut.r_mispredict_count = 16'hFFFD;
    #1;
    release dut.r_mispredict_count;
    m_cnt = 32'hFFFD;
    for (int i = 0; i < 4; i++) begin
      push(32'hA000 + 32'(i * 4), 1'b0, '0);
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'hB000);
      idle();
    end
    idle();

    phase = "reset_mid";
    push(32'hC000, 1'b1, 32'hC100);
    push(32'hC004, 1'b1, 32'hC200);
    push(32'hC008, 1'b0, 32'h0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'hC100);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    reset = 1'b0;
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'hC200);
    idle();
    push(32'hD000, 1'b1, 32'hD100);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'hD100);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolution_unit.md
BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 32, width of all PC and target fields.
REQ-002 SHALL have parameter DEPTH, default 4, in-flight prediction queue entries; power of two, 2 to 16.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port pred_valid, input, 1, predictor issues one prediction this cycle.
REQ-006 SHALL have port pred_pc, input, ADDRESS_BITS, PC of the predicted branch.
REQ-007 SHALL have port pred_taken, input, 1, predictor's taken/not-taken prediction.
REQ-008 SHALL have port pred_target, input, ADDRESS_BITS, predicted target address.
REQ-009 SHALL have port pred_ready, output, 1, queue accepts a prediction.
REQ-010 SHALL have port res_valid, input, 1, execute resolves the oldest in-flight branch.
REQ-011 SHALL have port res_taken, input, 1, actual branch outcome.
REQ-012 SHALL have port res_target, input, ADDRESS_BITS, actual target address.
REQ-013 SHALL have port res_ready, output, 1, a queued entry is available to resolve.
REQ-014 SHALL have port update_valid, output, 1, one-cycle predictor training strobe.
REQ-015 SHALL have port update_pc, output, ADDRESS_BITS, PC to train; drives predictor update_pc.
REQ-016 SHALL have port actual_pred, output, 1, actual outcome to train; drives predictor actual_pred.
REQ-017 SHALL have port flush, output, 1, one-cycle pipeline flush pulse on mispredict.
REQ-018 SHALL have port redirect_pc, output, ADDRESS_BITS, fetch restart address, valid while flush=1.
REQ-019 SHALL have port mispredict_count, output, 16, saturating mispredict counter.

Function
REQ-020 Queue SHALL be an in-order FIFO of {pc, taken, target}; push when pred_valid&&pred_ready, pop when res_valid&&res_ready.
REQ-021 pred_ready SHALL be 1 only in state RUN with queue not full; no same-cycle push-through-pop when full.
REQ-022 res_ready SHALL be 1 only in state RUN with queue not empty; a prediction pushed this cycle is not resolvable this cycle.
REQ-023 Push and pop in the same cycle SHALL both complete; occupancy unchanged; pointers wrap modulo DEPTH.
REQ-024 Mispredict SHALL be (head.taken != res_taken) OR (res_taken AND head.target != res_target).
REQ-025 On every pop, the next cycle SHALL assert update_valid=1, update_pc=head.pc, actual_pred=res_taken (one-cycle registered latency).
REQ-026 On a mispredicting pop, the next cycle SHALL also assert flush=1 with redirect_pc=res_taken ? res_target : head.pc+4 (modulo 2^ADDRESS_BITS).
REQ-027 On a mispredicting pop, the queue SHALL be emptied, a same-cycle push SHALL be discarded, and the FSM SHALL enter FLUSH.
REQ-028 FSM states: RUN, FLUSH; FLUSH lasts exactly one cycle (the flush-pulse cycle) with pred_ready=res_ready=0, then returns to RUN.
REQ-029 mispredict_count SHALL increment by 1 per mispredict and saturate at 16'hFFFF.
REQ-030 update_valid, flush SHALL be single-cycle pulses; update_pc, actual_pred, redirect_pc hold their last value when not strobed.

Reset
REQ-031 reset=1 SHALL asynchronously clear queue pointers and occupancy and force state RUN.
REQ-032 Reset values: pred_ready=1, res_ready=0, update_valid=0, update_pc=0, actual_pred=0, flush=0, redirect_pc=0, mispredict_count=0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight entries and any pending strobe; no update or flush emitted afterwards for them.

Structure
REQ-034 Shared package bpu_pkg SHALL hold the state enum (RUN, FLUSH), the queue-entry struct type, and constant INSTR_BYTES=4.
REQ-035 The FIFO SHALL be a sub-module bru_pred_fifo (parameterised DEPTH/width, push/pop/clear, full/empty); FSM, compare, counter stay in the top.

Verification
REQ-036 Push pc=0x10 taken=1 target=0x30; resolve taken=1 target=0x30 -> next cycle update_valid=1, update_pc=0x10, actual_pred=1, flush=0, count=0.
REQ-037 Push pc=0x20 taken=0; resolve taken=1 target=0x80 -> flush=1, redirect_pc=0x80, count=1, queue empty, following cycle pred_ready=0, then 1.
REQ-038 Push pc=0x3C taken=1 target=0x100; resolve taken=0 -> flush=1, redirect_pc=0x40, actual_pred=0, update_pc=0x3C.
REQ-039 Fill 4 entries -> pred_ready=0; simultaneous 5th push and correct resolve -> pop only; next cycle push accepted; pointer wrap verified over 3 laps.
REQ-040 Three queued, oldest mispredicts with simultaneous push -> all discarded, res_ready=0 for two cycles, no further update_valid.
REQ-041 Force 65537 mispredicts (or preload counter near max) -> mispredict_count holds 16'hFFFF; reset mid-queue -> all outputs at REQ-032 values immediately.
